// File: rtl/countdown_timer_ctrl.sv
// One-shot N-bit countdown sequencer with pause/abort and a 1-cycle done pulse; count=L one edge after start, done one edge after count reaches 0.
// Optional AUTO_RELOAD_EN adds an auto_reload input that turns the timer periodic (period L+1).
module countdown_timer_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         pause,
  input  logic         abort,
`ifdef AUTO_RELOAD_EN
  input  logic         auto_reload,
`endif
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         pulse_q, pulse_d;
  logic         reload_en;

`ifdef AUTO_RELOAD_EN
  assign reload_en = auto_reload;
`else
  assign reload_en = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pulse_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count_q == '0) begin
            // Periodic mode reloads in place and flags the period with a registered pulse.
            if (reload_en) begin
              count_d = reload_q;
              pulse_d = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            count_d = count_q - N'(1);
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        DONE: begin
          if (start) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = (state_q == DONE) || pulse_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboarded bench for countdown_timer_ctrl: directed scenarios followed by random traffic.
module tb_countdown_timer_ctrl;

  typedef struct packed {
    logic [2:0] count;
    logic [1:0] state;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       auto_reload = 1'b0;
  logic [2:0] count;
  logic       busy, done;
  logic [1:0] state;

  countdown_timer_ctrl #(.N(3)) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .load_val(load_val),
    .pause(pause),
    .abort(abort),
`ifdef AUTO_RELOAD_EN
    .auto_reload(auto_reload),
`endif
    .count(count),
    .busy(busy),
    .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

`ifdef AUTO_RELOAD_EN
  localparam bit AR_BUILD = 1'b1;
`else
  localparam bit AR_BUILD = 1'b0;
`endif

  // Reference model: phase names instead of an encoding, plain integer countdown.
  int   m_phase;   // 0 idle, 1 counting, 2 frozen, 3 expired
  int   m_left;
  int   m_period;
  bit   m_tick;
  int   clr_lvl = 1;
  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.count = 3'(m_left);
    o.state = 2'(m_phase);
    o.busy  = (m_phase == 1 || m_phase == 2);
    o.done  = (m_phase == 3) || m_tick;
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_period = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit s, input int lv, input bit p, input bit a, input bit ar);
    bit can_load;
    m_tick = 0;
    can_load = (m_phase == 0 || m_phase == 3) && s;
    if (a) begin
      m_phase = 0; m_left = 0;
    end else if (can_load) begin
      m_left = lv; m_period = lv; m_phase = 1;
    end else if (m_phase == 3) begin
      m_phase = 0;
    end else if (m_phase == 2) begin
      if (!p) m_phase = 1;
    end else if (m_phase == 1) begin
      if (p) m_phase = 2;
      else if (m_left > 0) m_left = m_left - 1;
      else if (AR_BUILD && ar) begin m_left = m_period; m_tick = 1; end
      else m_phase = 3;
    end
  endtask

  task automatic step(input bit s, input int lv, input bit p, input bit a, input bit ar);
    @(negedge clk);
    clr = clr_lvl[0];
    start = s; load_val = 3'(lv); pause = p; abort = a; auto_reload = ar;
    if (clr_lvl == 0) model_reset();
    else model_edge(s, lv, p, a, ar);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Reset lands mid-cycle, well away from any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    model_reset();
    exp_q.push_back(model_obs());
    clr = 1'b0;
    clr_lvl = 0;
    idle(2);
    clr_lvl = 1;
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk or negedge clr);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{count: count, state: state, busy: busy, done: done};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got count=%0d state=%0d busy=%0b done=%0b, want count=%0d state=%0d busy=%0b done=%0b",
                   vectors, $time, a.count, a.state, a.busy, a.done, e.count, e.state, e.busy, e.done);
        end
      end
    end
  end

  initial begin : stim
    model_reset();
    async_reset();

    // Mid-count reset at count=5.
    step(1, 7, 0, 0, 0);
    idle(2);
    async_reset();

    // Plain countdown from 5 through done back to idle.
    step(1, 5, 0, 0, 0);
    idle(8);

    // Pause at count=2 for three cycles, then resume.
    step(1, 3, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    idle(4);

    // Start ignored while running, then abort at 4.
    step(1, 7, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    idle(2);

    // Zero load, then back-to-back restart from DONE.
    step(1, 0, 0, 0, 0);
    idle(1);
    step(1, 2, 0, 0, 0);
    idle(4);

    // Abort wins over start in DONE.
    step(1, 0, 0, 0, 0);
    idle(1);
    step(1, 4, 0, 1, 0);
    idle(2);

    if (AR_BUILD) begin
      step(1, 2, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
      idle(5);
    end

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    if (vectors < 1000) begin
      miscompares++;
      $display("FAIL volume: %0d vectors checked, want at least 1000", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
